// File: rtl/ram_pkg.sv
// Shared owner encodings and default geometry for the RAM arbiter; no logic.
// Pure declarations: zero latency, no handshake of its own.
package ram_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;

  localparam logic [1:0] OWN_IDLE    = 2'b00;
  localparam logic [1:0] OWN_CPU     = 2'b01;
  localparam logic [1:0] OWN_LD      = 2'b10;
  localparam logic [1:0] OWN_LD_LOCK = 2'b11;

  // Counter must hold 0..max inclusive, and never collapse to zero width.
  function automatic int starve_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter: grant and mem drive same cycle, read data one cycle later.
// No queuing: a losing requester holds its request; the loader is forced through after STARVE_MAX losses.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int              SW         = starve_width(STARVE_MAX);
  localparam logic [SW-1:0]   STARVE_SAT = SW'(STARVE_MAX);

  logic [1:0]    owner_q, owner_d;
  logic [SW-1:0] starve, starve_d;
  logic          cpu_rv_q, ld_rv_q;
  logic          lock_hold, ld_win, cpu_win;

  // Winner selection; reset suppresses every grant.
  always_comb begin
    ld_win    = 1'b0;
    cpu_win   = 1'b0;
    lock_hold = (owner_q == OWN_LD_LOCK) && ld_req && ld_lock;
    if (reset) begin
      if (lock_hold) begin
        ld_win = 1'b1;
      end else if (ld_req && (!cpu_req || starve == STARVE_SAT)) begin
        ld_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (ld_win) begin
      owner_d = ld_lock ? OWN_LD_LOCK : OWN_LD;
    end else if (cpu_win) begin
      owner_d = OWN_CPU;
    end
  end

  // Losses only count while the loader is actually waiting.
  always_comb begin
    starve_d = starve;
    if (!ld_req || ld_win) begin
      starve_d = '0;
    end else if (cpu_win && starve != STARVE_SAT) begin
      starve_d = starve + SW'(1);
    end
  end

  always_comb begin
    mem_en    = ld_win | cpu_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_win) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q  <= OWN_IDLE;
      starve   <= '0;
      cpu_rv_q <= 1'b0;
      ld_rv_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve   <= starve_d;
      cpu_rv_q <= cpu_win && !cpu_we;
      ld_rv_q  <= ld_win && !ld_we;
    end
  end

  // Masking with reset keeps a read granted just before reset from ever surfacing.
  assign cpu_rvalid = cpu_rv_q & reset;
  assign ld_rvalid  = ld_rv_q & reset;
  assign cpu_gnt    = cpu_win;
  assign ld_gnt     = ld_win;
  assign rdata      = mem_rdata;
  assign owner      = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench with a per-cycle expectation scoreboard and a behavioural single-port RAM.
module tb_ram_arbiter;

  logic       clock;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
  logic [4:0] ld_addr;
  logic [7:0] ld_wdata;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [1:0] owner;

  ram_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] ram [0:31];
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       cg, lg, en, we;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       crv, lrv;
    logic [1:0] own;
    logic       rdc;
    logic [7:0] rd;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;

  task automatic chk(input int tag, input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, tag, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "cpu_gnt", int'(cpu_gnt), int'(e.cg));
      chk(e.tag, "ld_gnt", int'(ld_gnt), int'(e.lg));
      chk(e.tag, "mem_en", int'(mem_en), int'(e.en));
      chk(e.tag, "mem_we", int'(mem_we), int'(e.we));
      chk(e.tag, "cpu_rvalid", int'(cpu_rvalid), int'(e.crv));
      chk(e.tag, "ld_rvalid", int'(ld_rvalid), int'(e.lrv));
      chk(e.tag, "owner", int'(owner), int'(e.own));
      if (e.en) chk(e.tag, "mem_addr", int'(mem_addr), int'(e.addr));
      if (e.we) chk(e.tag, "mem_wdata", int'(mem_wdata), int'(e.wd));
      if (e.rdc) chk(e.tag, "rdata", int'(rdata), int'(e.rd));
    end
  end

  task automatic cpu(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ld(input logic r, input logic w, input logic lk, input logic [4:0] a,
                    input logic [7:0] d);
    ld_req = r; ld_we = w; ld_lock = lk; ld_addr = a; ld_wdata = d;
  endtask

  task automatic idle();
    cpu(1'b0, 1'b0, 5'd0, 8'h00);
    ld(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  // Queue the expected response for the cycle whose inputs are now applied, then advance.
  task automatic cyc(input logic cg, input logic lg, input logic en, input logic we,
                     input logic [4:0] addr, input logic [7:0] wd, input logic crv,
                     input logic lrv, input logic [1:0] own, input logic rdc,
                     input logic [7:0] rd);
    exp_t e;
    cyc_n++;
    e.cg = cg; e.lg = lg; e.en = en; e.we = we; e.addr = addr; e.wd = wd;
    e.crv = crv; e.lrv = lrv; e.own = own; e.rdc = rdc; e.rd = rd; e.tag = cyc_n;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    cpu(1'b1, 1'b0, 5'd0, 8'h00);
    ld(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    @(posedge clock);
    #1;
    // Reset held with both requesting: nothing granted.
    repeat (2) cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);
    reset = 1'b1;
    idle();
    repeat (3) cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Conflict: CPU wins four times, then the starved loader, then CPU again.
    cpu(1'b1, 1'b0, 5'd1, 8'h00);
    ld(1'b1, 1'b1, 1'b0, 5'd2, 8'h11);
    cyc(1,0,1,0, 5'd1,8'h00, 0,0, 2'd0, 0,8'h00);
    repeat (3) cyc(1,0,1,0, 5'd1,8'h00, 1,0, 2'd1, 1,8'h00);
    cyc(0,1,1,1, 5'd2,8'h11, 1,0, 2'd1, 1,8'h00);
    cyc(1,0,1,0, 5'd1,8'h00, 0,0, 2'd2, 0,8'h00);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 1,0, 2'd1, 1,8'h00);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Locked burst writes i at address i; CPU requests throughout but is shut out.
    ld(1'b1, 1'b1, 1'b1, 5'd0, 8'h00);
    cyc(0,1,1,1, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);
    cpu(1'b1, 1'b0, 5'd5, 8'h00);
    for (int i = 1; i < 4; i++) begin
      ld(1'b1, 1'b1, 1'b1, 5'(i), 8'(i));
      cyc(0,1,1,1, 5'(i),8'(i), 0,0, 2'd3, 0,8'h00);
    end
    // Lock dropped while loader still requests: CPU wins that same cycle.
    ld(1'b1, 1'b1, 1'b0, 5'd4, 8'h04);
    cyc(1,0,1,0, 5'd5,8'h00, 0,0, 2'd3, 0,8'h00);
    cpu(1'b0, 1'b0, 5'd0, 8'h00);
    cyc(0,1,1,1, 5'd4,8'h04, 1,0, 2'd1, 1,8'h00);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd2, 0,8'h00);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Read latency: loader writes A7 at 5, CPU reads it back.
    ld(1'b1, 1'b1, 1'b0, 5'd5, 8'hA7);
    cyc(0,1,1,1, 5'd5,8'hA7, 0,0, 2'd0, 0,8'h00);
    idle();
    cpu(1'b1, 1'b0, 5'd5, 8'h00);
    cyc(1,0,1,0, 5'd5,8'h00, 0,0, 2'd2, 0,8'h00);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 1,0, 2'd1, 1,8'hA7);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Loader read of burst data, overlapped with a CPU read.
    ld(1'b1, 1'b0, 1'b0, 5'd2, 8'h00);
    cyc(0,1,1,0, 5'd2,8'h00, 0,0, 2'd0, 0,8'h00);
    idle();
    cpu(1'b1, 1'b0, 5'd3, 8'h00);
    cyc(1,0,1,0, 5'd3,8'h00, 0,1, 2'd2, 1,8'h02);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 1,0, 2'd1, 1,8'h03);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Reset the cycle after a loader read grant: its rvalid must never appear.
    ld(1'b1, 1'b0, 1'b0, 5'd1, 8'h00);
    cyc(0,1,1,0, 5'd1,8'h00, 0,0, 2'd0, 0,8'h00);
    reset = 1'b0;
    cpu(1'b1, 1'b0, 5'd1, 8'h00);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd2, 0,8'h00);
    reset = 1'b1;
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    // Idle loader: ten CPU grants, then starvation must still take the full four losses.
    cpu(1'b1, 1'b0, 5'd3, 8'h00);
    cyc(1,0,1,0, 5'd3,8'h00, 0,0, 2'd0, 0,8'h00);
    repeat (9) cyc(1,0,1,0, 5'd3,8'h00, 1,0, 2'd1, 1,8'h03);
    ld(1'b1, 1'b1, 1'b0, 5'd9, 8'h5C);
    repeat (4) cyc(1,0,1,0, 5'd3,8'h00, 1,0, 2'd1, 1,8'h03);
    cyc(0,1,1,1, 5'd9,8'h5C, 1,0, 2'd1, 1,8'h03);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd2, 0,8'h00);
    cpu(1'b1, 1'b0, 5'd9, 8'h00);
    cyc(1,0,1,0, 5'd9,8'h00, 0,0, 2'd0, 0,8'h00);
    idle();
    cyc(0,0,0,0, 5'd0,8'h00, 1,0, 2'd1, 1,8'h5C);
    cyc(0,0,0,0, 5'd0,8'h00, 0,0, 2'd0, 0,8'h00);

    @(negedge clock);
    #1;
    chk(cyc_n, "scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
